// File: rtl/cordic_gain_compensator.sv
// cordic_gain_compensator: removes CORDIC gain from x/y with a bit-serial shift-add multiply.
// Define CORDIC_GAIN_SAT_EN to saturate out-of-range results and flag ovf; otherwise results wrap.
`ifndef CIRCULAR
`define CIRCULAR 2'd0
`endif
`ifndef LINEAR
`define LINEAR 2'd1
`endif
`ifndef HYPERBOLIC
`define HYPERBOLIC 2'd2
`endif

module cordic_gain_compensator #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 20,
  parameter int KFRAC = 30
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] rotated_x,
  input  logic [WIDTH-1:0] rotated_y,
  input  logic [WIDTH-1:0] final_angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] comp_x,
  output logic [WIDTH-1:0] comp_y,
  output logic [WIDTH-1:0] comp_angle,
  output logic             ovf
);
  localparam int KW = KFRAC + 2;
  localparam int CW = $clog2(KW);
  localparam int AW = 2 * WIDTH;
  localparam logic [KW-1:0] K_CIRC = KW'(64'd652032874);
  localparam logic [KW-1:0] K_HYP  = KW'(64'd1296540104);
  localparam logic signed [AW-1:0] HALF = AW'(1) << (KFRAC - 1);

  // The gain constants are fixed Q2.30 values and the product must fit the accumulator.
  if (KFRAC != 30 || FRAC >= WIDTH || AW < WIDTH + KW) begin : g_bad_cfg
    $error("cordic_gain_compensator: unsupported WIDTH/FRAC/KFRAC combination");
  end

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, ang_q, ang_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [WIDTH-1:0]     comp_x_q, comp_x_d, comp_y_q, comp_y_d, comp_angle_q, comp_angle_d;
  logic                 ovf_q, ovf_d;

  logic                 bypass, accept, last;
  logic [KW-1:0]        k_sel;
  logic signed [AW-1:0] ext_x, ext_y, sum_x, sum_y;
  logic [WIDTH:0]       fin_x, fin_y;

  // Returns {ovf, value} for the rounded, rescaled accumulator.
  function automatic logic [WIDTH:0] round_sat(input logic signed [AW-1:0] acc);
`ifdef CORDIC_GAIN_SAT_EN
    logic signed [AW-1:0] r;
    r = (acc + HALF) >>> KFRAC;
    round_sat = (&r[AW-1:WIDTH-1] || ~|r[AW-1:WIDTH-1]) ? {1'b0, r[WIDTH-1:0]}
              : {1'b1, r[AW-1], {(WIDTH-1){~r[AW-1]}}};
`else
    round_sat = {1'b0, WIDTH'((acc + HALF) >>> KFRAC)};
`endif
  endfunction

  assign bypass = (mode != `CIRCULAR) && (mode != `HYPERBOLIC);
  assign k_sel  = (mode == `CIRCULAR) ? K_CIRC : K_HYP;
  assign accept = in_ready && in_valid;
  assign last   = cnt_q == CW'(KW - 1);
  assign ext_x  = {{(AW-WIDTH){x_q[WIDTH-1]}}, x_q};
  assign ext_y  = {{(AW-WIDTH){y_q[WIDTH-1]}}, y_q};
  assign sum_x  = acc_x_q + (k_q[cnt_q] ? ext_x << cnt_q : '0);
  assign sum_y  = acc_y_q + (k_q[cnt_q] ? ext_y << cnt_q : '0);
  assign fin_x  = round_sat(sum_x);
  assign fin_y  = round_sat(sum_y);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? (bypass ? DONE : MUL) : IDLE;
      MUL:     state_d = last ? DONE : MUL;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    ang_d        = ang_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    comp_x_d     = comp_x_q;
    comp_y_d     = comp_y_q;
    comp_angle_d = comp_angle_q;
    ovf_d        = ovf_q;
    if (accept) begin
      x_d     = rotated_x;
      y_d     = rotated_y;
      ang_d   = final_angle;
      k_d     = k_sel;
      cnt_d   = '0;
      acc_x_d = '0;
      acc_y_d = '0;
      if (bypass) begin
        comp_x_d     = rotated_x;
        comp_y_d     = rotated_y;
        comp_angle_d = final_angle;
        ovf_d        = 1'b0;
      end
    end else if (state_q == MUL) begin
      cnt_d   = cnt_q + CW'(1);
      acc_x_d = sum_x;
      acc_y_d = sum_y;
      if (last) begin
        comp_x_d     = fin_x[WIDTH-1:0];
        comp_y_d     = fin_y[WIDTH-1:0];
        comp_angle_d = ang_q;
        ovf_d        = fin_x[WIDTH] | fin_y[WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q          <= '0;
      y_q          <= '0;
      ang_q        <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      comp_x_q     <= '0;
      comp_y_q     <= '0;
      comp_angle_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      ang_q        <= ang_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      comp_x_q     <= comp_x_d;
      comp_y_q     <= comp_y_d;
      comp_angle_q <= comp_angle_d;
      ovf_q        <= ovf_d;
    end
  end

  assign comp_x     = comp_x_q;
  assign comp_y     = comp_y_q;
  assign comp_angle = comp_angle_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_cordic_gain_compensator.sv
// tb_cordic_gain_compensator: table vectors, flow-control/reset sequences and random samples
// checked against a multiply-based reference model (honours CORDIC_GAIN_SAT_EN).
`ifndef CIRCULAR
`define CIRCULAR 2'd0
`endif
`ifndef LINEAR
`define LINEAR 2'd1
`endif
`ifndef HYPERBOLIC
`define HYPERBOLIC 2'd2
`endif

module tb_cordic_gain_compensator;
  logic        clock, reset_n, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [1:0]  mode;
  logic [31:0] rotated_x, rotated_y, final_angle, comp_x, comp_y, comp_angle;
  int          n_vec = 0;
  int          n_bad = 0;
  longint      k_c, k_h;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  cordic_gain_compensator dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .rotated_x(rotated_x), .rotated_y(rotated_y), .final_angle(final_angle),
    .out_valid(out_valid), .out_ready(out_ready), .comp_x(comp_x), .comp_y(comp_y),
    .comp_angle(comp_angle), .ovf(ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  m;
    logic [31:0] x, y, a, ex, ey;
    logic        eo;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: exact product, round half up, then saturate or wrap.
  function automatic logic [32:0] model(input logic [1:0] m, input logic [31:0] v);
    longint k, p, r;
    if (m == `CIRCULAR) k = k_c;
    else if (m == `HYPERBOLIC) k = k_h;
    else return {1'b0, v};
    p = longint'($signed(v)) * k;
    r = (p + (64'sd1 <<< 29)) >>> 30;
`ifdef CORDIC_GAIN_SAT_EN
    if (r > MAXV) return {1'b1, 32'h7FFFFFFF};
    if (r < MINV) return {1'b1, 32'h80000000};
`endif
    return {1'b0, r[31:0]};
  endfunction

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic run(input string nm, input logic [1:0] m, input logic [31:0] x, y, a, ex, ey,
                     input logic eo, input int elat, input int hold, input bit consume);
    int lat;
    @(negedge clock);
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    mode = m; rotated_x = x; rotated_y = y; final_angle = a; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; mode = 2'($urandom); rotated_x = $urandom; rotated_y = $urandom;
    final_angle = $urandom;
    wait_out(lat);
    chk({nm, ".latency"}, 32'(lat), 32'(elat));
    repeat (hold) begin
      @(posedge clock);
      #1;
    end
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".comp_x"}, comp_x, ex);
    chk({nm, ".comp_y"}, comp_y, ey);
    chk({nm, ".comp_angle"}, comp_angle, a);
    chk({nm, ".ovf"}, 32'(ovf), 32'(eo));
    if (consume) begin
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk({nm, ".drop_valid"}, 32'(out_valid), 32'd0);
      chk({nm, ".ready_again"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [32:0] rx, ry, dx, dy;
    int lat, seen;
    k_c = longint'($rtoi(0.6072529350 * 1073741824.0 + 0.5));
    k_h = longint'($rtoi(1.2074970677 * 1073741824.0 + 0.5));
    tbl[0] = '{`CIRCULAR,   32'h00100000, 32'h00000000, 32'h11111111, 32'h0009B74F, 32'h00000000, 1'b0, 33};
    tbl[1] = '{`HYPERBOLIC, 32'h00100000, 32'hFFF00000, 32'h22222222, 32'h001351E8, 32'hFFECAE18, 1'b0, 33};
    tbl[2] = '{`LINEAR,     32'h12345678, 32'hCAFEBABE, 32'h0AAAAAAA, 32'h12345678, 32'hCAFEBABE, 1'b0, 1};
    tbl[3] = '{2'd3,        32'h80000001, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h80000001, 32'h7FFFFFFF, 1'b0, 1};
`ifdef CORDIC_GAIN_SAT_EN
    tbl[4] = '{`HYPERBOLIC, 32'h7FFFFFFF, 32'h80000000, 32'h00000003, 32'h7FFFFFFF, 32'h80000000, 1'b1, 33};
`else
    tbl[4] = '{`HYPERBOLIC, 32'h7FFFFFFF, 32'h80000000, 32'h00000003, 32'h9A8F438F, 32'h6570BC70, 1'b0, 33};
`endif
    tbl[5] = '{`CIRCULAR,   32'hFFF00000, 32'h00080000, 32'h00000000, 32'hFFF648B1, 32'h0004DBA7, 1'b0, 33};

    in_valid = 1'b0; out_ready = 1'b0; mode = `LINEAR;
    rotated_x = '0; rotated_y = '0; final_angle = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.comp_x", comp_x, 32'd0);
    chk("reset.comp_y", comp_y, 32'd0);
    chk("reset.comp_angle", comp_angle, 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run($sformatf("tbl%0d", i), tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].ex, tbl[i].ey,
          tbl[i].eo, tbl[i].lat, i % 2, 1'b1);

    // Backpressure: hold DONE for 20 cycles while a new sample is offered.
    rx = model(`CIRCULAR, 32'h00300000);
    ry = model(`CIRCULAR, 32'hFFF80000);
    run("bp.first", `CIRCULAR, 32'h00300000, 32'hFFF80000, 32'h00000055, rx[31:0], ry[31:0], 1'b0, 33, 0, 1'b0);
    dx = model(`CIRCULAR, 32'h00200000);
    dy = model(`CIRCULAR, 32'h00010000);
    @(negedge clock);
    mode = `CIRCULAR; rotated_x = 32'h00200000; rotated_y = 32'h00010000; final_angle = 32'h77; in_valid = 1'b1;
    repeat (20) begin
      @(posedge clock);
      #1;
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
      chk("bp.hold_x", comp_x, rx[31:0]);
      chk("bp.hold_angle", comp_angle, 32'h55);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("bp.second_latency", 32'(lat), 32'd33);
    chk("bp.second_x", comp_x, dx[31:0]);
    chk("bp.second_y", comp_y, dy[31:0]);
    chk("bp.second_angle", comp_angle, 32'h77);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;

    // Reset during MUL aborts the sample.
    @(negedge clock);
    mode = `HYPERBOLIC; rotated_x = 32'h00100000; rotated_y = 32'h00100000; final_angle = 32'h9; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.comp_x", comp_x, 32'd0);
    chk("abort.comp_y", comp_y, 32'd0);
    chk("abort.comp_angle", comp_angle, 32'd0);
    chk("abort.ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (out_valid) seen++;
    end
    chk("abort.no_result", 32'(seen), 32'd0);
    rx = model(`HYPERBOLIC, 32'hFFE80000);
    ry = model(`HYPERBOLIC, 32'h00040000);
    run("abort.fresh", `HYPERBOLIC, 32'hFFE80000, 32'h00040000, 32'h00000ABC, rx[31:0], ry[31:0],
        rx[32] | ry[32], 33, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] m;
      logic [31:0] x, y, a;
      logic signed [23:0] s;
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        x = $urandom;
        y = $urandom;
      end else begin
        s = 24'($urandom);
        x = 32'(s);
        s = 24'($urandom);
        y = 32'(s);
      end
      a = $urandom;
      rx = model(m, x);
      ry = model(m, y);
      run($sformatf("rnd%0d", i), m, x, y, a, rx[31:0], ry[31:0], rx[32] | ry[32],
          (m == `CIRCULAR || m == `HYPERBOLIC) ? 33 : 1, $urandom_range(0, 3), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
